// File: rtl/mult_acc_if.sv
// Handshake bundle between the multiplier stage, the accumulator and the result consumer.
interface mult_acc_if #(
  parameter int N     = 32,
  parameter int ACC_W = 2*N+8
);
  logic                    start;
  logic [7:0]              len;
  logic                    prod_valid;
  logic                    prod_ready;
  logic signed [2*N-1:0]   product;
  logic                    acc_valid;
  logic                    acc_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    busy;
  logic                    ovf;

  modport master (output start, len, prod_valid, product, acc_ready,
                  input  prod_ready, acc_valid, acc_out, busy, ovf);
  modport slave  (input  start, len, prod_valid, product, acc_ready,
                  output prod_ready, acc_valid, acc_out, busy, ovf);
endinterface

// File: rtl/mult_accumulator.sv
// Accumulates len signed products, then holds the sum until the consumer takes it.
// Define MULT_ACC_SAT_EN to saturate on overflow and report it on ovf; otherwise the sum wraps.
module mult_accumulator #(
  parameter int N     = 32,
  parameter int ACC_W = 2*N+8
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                  state, nxt_state;
  logic signed [ACC_W-1:0] acc, nxt_acc, prod_ext, sum;
  logic [7:0]              cnt, nxt_cnt;
  logic                    take;

  assign prod_ext = ACC_W'($signed(bus.product));
  assign sum      = acc + prod_ext;
  assign take     = (state == ACCUM) && bus.prod_valid;

`ifdef MULT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
  logic ovf, nxt_ovf, add_ovf;
  // Same-sign operands producing a different-sign result is a signed overflow.
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`endif

  always_comb begin
    nxt_state = state;
    nxt_acc   = acc;
    nxt_cnt   = cnt;
`ifdef MULT_ACC_SAT_EN
    nxt_ovf   = ovf;
`endif
    unique case (state)
      IDLE: if (bus.start) begin
        nxt_acc   = '0;
        nxt_cnt   = bus.len;
`ifdef MULT_ACC_SAT_EN
        nxt_ovf   = 1'b0;
`endif
        nxt_state = (bus.len == 8'd0) ? HOLD : ACCUM;
      end
      ACCUM: if (take) begin
        nxt_cnt = cnt - 8'd1;
        nxt_acc = sum;
`ifdef MULT_ACC_SAT_EN
        if (add_ovf) begin
          nxt_acc = acc[ACC_W-1] ? MINV : MAXV;
          nxt_ovf = 1'b1;
        end
`endif
        if (cnt == 8'd1) nxt_state = HOLD;
      end
      HOLD: if (bus.acc_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
`ifdef MULT_ACC_SAT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      acc   <= nxt_acc;
      cnt   <= nxt_cnt;
`ifdef MULT_ACC_SAT_EN
      ovf   <= nxt_ovf;
`endif
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.acc_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.acc_out    = acc;
`ifdef MULT_ACC_SAT_EN
  assign bus.ovf        = ovf;
`else
  assign bus.ovf        = 1'b0;
`endif
endmodule

// File: tb/tb_mult_accumulator.sv
// Randomized and directed bench for mult_accumulator; expected sums come from a queue-based model.
module tb_mult_accumulator;
  localparam int N   = 32;
  localparam int AW  = 72;
  localparam int AW2 = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_acc_if #(.N(N), .ACC_W(AW))  bus  ();
  mult_acc_if #(.N(N), .ACC_W(AW2)) bus2 ();

  mult_accumulator #(.N(N), .ACC_W(AW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mult_accumulator #(.N(N), .ACC_W(AW2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int failures = 0;

  logic signed [AW-1:0]  exp_q[$];
  logic signed [2*N-1:0] pq[$];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Result checker: whenever a result is offered it must match the oldest expected sum,
  // and it must stay put until taken.
  initial begin
    logic           prev_hold;
    logic [AW-1:0]  prev_out;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (bus.acc_valid) begin
          if (exp_q.size() == 0) chk1("sb_unexpected_result", 1'b1, 1'b0);
          else begin
            chk("sb_acc_out", bus.acc_out, exp_q[0]);
            chk1("sb_ovf", bus.ovf, 1'b0);
          end
          chk1("sb_busy_in_hold", bus.busy, 1'b1);
          chk1("sb_prod_ready_in_hold", bus.prod_ready, 1'b0);
        end
        if (prev_hold) begin
          chk1("sb_hold_valid", bus.acc_valid, 1'b1);
          chk("sb_hold_stable", bus.acc_out, prev_out);
        end
        prev_hold = bus.acc_valid && !bus.acc_ready;
        prev_out  = bus.acc_out;
        if (bus.acc_valid && bus.acc_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit strays);
    if (strays) begin
      bus.start = 1'b1;
      bus.len   = 8'($urandom);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic start_txn(input int l);
    bus.start = 1'b1;
    bus.len   = 8'(l);
    tick();
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
  endtask

  task automatic send(input logic signed [2*N-1:0] p);
    int k;
    k = 0;
    bus.prod_valid = 1'b1;
    bus.product    = p;
    @(negedge clk);
    while (!bus.prod_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.prod_ready) chk1("prod_ready_timeout", 1'b0, 1'b1);
    tick();
    bus.prod_valid = 1'b0;
    bus.product    = {$urandom, $urandom};
  endtask

  task automatic run_txn(input int gapmax, input bit fixed, input int holdmax, input bit strays,
                         output logic signed [AW-1:0] model);
    int l, g, h;
    l = pq.size();
    model = '0;
    foreach (pq[i]) model += AW'(pq[i]);
    start_txn(l);
    for (int i = 0; i < l; i++) begin
      g = fixed ? gapmax : int'($urandom_range(gapmax, 0));
      repeat (g) idle_cycle(strays);
      send(pq[i]);
    end
    exp_q.push_back(model);
    @(negedge clk);
    chk1("acc_valid_latency", bus.acc_valid, 1'b1);
    @(posedge clk);
    #1;
    h = fixed ? holdmax : int'($urandom_range(holdmax, 0));
    repeat (h) idle_cycle(strays);
    bus.acc_ready = 1'b1;
    bus.start     = strays;
    tick();
    bus.acc_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk1("idle_after_accept_busy", bus.busy, 1'b0);
    chk1("idle_after_accept_valid", bus.acc_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [AW-1:0] m;
    bus.start = 1'b0;  bus.len = '0;  bus.prod_valid = 1'b0;  bus.product = '0;  bus.acc_ready = 1'b0;
    bus2.start = 1'b0; bus2.len = '0; bus2.prod_valid = 1'b0; bus2.product = '0; bus2.acc_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("reset_prod_ready", bus.prod_ready, 1'b0);
    chk1("reset_acc_valid", bus.acc_valid, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_ovf", bus.ovf, 1'b0);
    chk("reset_acc_out", bus.acc_out, '0);
    chk1("reset_ovf_w64", bus2.ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 6 - 10 + 7
    pq.delete(); pq.push_back(64'sd6); pq.push_back(-64'sd10); pq.push_back(64'sd7);
    run_txn(0, 1'b1, 0, 1'b0, m);
    chk("model_len3", m, 72'd3);

    // zero-length request returns 0 immediately
    pq.delete();
    run_txn(0, 1'b1, 0, 1'b0, m);
    chk("model_len0", m, 72'd0);

    // gapped products, long hold, stray starts everywhere
    pq.delete(); pq.push_back(64'sd100); pq.push_back(-64'sd1);
    run_txn(4, 1'b1, 5, 1'b1, m);
    chk("model_gapped", m, 72'd99);

    // reset mid-accumulation abandons the result
    start_txn(4);
    send(64'sd1);
    send(64'sd2);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_prod_ready", bus.prod_ready, 1'b0);
    chk1("midrst_acc_valid", bus.acc_valid, 1'b0);
    chk1("midrst_ovf", bus.ovf, 1'b0);
    chk("midrst_acc_out", bus.acc_out, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    pq.delete(); pq.push_back(64'sd5);
    run_txn(0, 1'b1, 0, 1'b0, m);
    chk("model_after_rst", m, 72'd5);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      int l;
      l = ($urandom_range(7, 0) == 0) ? 20 : int'($urandom_range(8, 0));
      pq.delete();
      for (int i = 0; i < l; i++) begin
        logic signed [2*N-1:0] p;
        p = ($urandom_range(1, 0) == 0) ? {$urandom, $urandom} : 64'(signed'(16'($urandom)));
        pq.push_back(p);
      end
      run_txn(3, 1'b0, 3, 1'($urandom_range(1, 0)), m);
    end

    // 64-bit accumulator overflow behaviour
    bus2.start = 1'b1; bus2.len = 8'd2;
    tick();
    bus2.start = 1'b0;
    bus2.prod_valid = 1'b1;
    bus2.product = 64'h7FFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk1("w64_prod_ready0", bus2.prod_ready, 1'b1);
    tick();
    @(negedge clk);
    chk1("w64_prod_ready1", bus2.prod_ready, 1'b1);
    tick();
    bus2.prod_valid = 1'b0;
    @(negedge clk);
    chk1("w64_acc_valid", bus2.acc_valid, 1'b1);
`ifdef MULT_ACC_SAT_EN
    chk("w64_acc_out", {8'h0, bus2.acc_out}, {8'h0, 64'h7FFF_FFFF_FFFF_FFFF});
    chk1("w64_ovf", bus2.ovf, 1'b1);
`else
    chk("w64_acc_out", {8'h0, bus2.acc_out}, {8'h0, 64'hFFFF_FFFF_FFFF_FFFE});
    chk1("w64_ovf", bus2.ovf, 1'b0);
`endif
    @(posedge clk);
    #1;
    bus2.acc_ready = 1'b1;
    tick();
    bus2.acc_ready = 1'b0;
    @(negedge clk);
    chk1("w64_idle_busy", bus2.busy, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", AW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
